dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester, response and Data_Memory signals of the two-port data-memory arbiter.
// The arbiter uses the slave view; the requesters and memory model use the master view.
interface dmem_arbiter_if;
    // core requester
    logic        c_req;
    logic        c_we;
    logic [63:0] c_addr;
    logic [63:0] c_wdata;
    logic        c_gnt;
    logic        c_rvalid;
    logic [63:0] c_rdata;
    // loader requester
    logic        l_req;
    logic        l_we;
    logic [63:0] l_addr;
    logic [63:0] l_wdata;
    logic        l_gnt;
    logic        l_rvalid;
    logic [63:0] l_rdata;
    // Data_Memory side
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic        m_MemRead;
    logic        m_MemWrite;
    logic [63:0] m_rdata;
    // status
    logic        busy;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  m_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output l_gnt, l_rvalid, l_rdata,
        output m_addr, m_wdata, m_MemRead, m_MemWrite,
        output busy
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata,
        output m_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  m_addr, m_wdata, m_MemRead, m_MemWrite,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (core, loader) arbiter in front of a single Data_Memory port.
// One transaction at a time: IDLE samples requests, ISSUE drives the memory
// strobe for one cycle, WAIT covers the memory latency for loads, RESP returns
// the load data. Ties are broken round-robin; every output is a flop.
module dmem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Counter start value for WAIT; unused when there is no latency.
    localparam logic [1:0] LAT_M1 = (MEM_LAT > 0) ? 2'(MEM_LAT - 1) : 2'd0;

    // Encoding of requester ids: 0 = core, 1 = loader.
    localparam logic ID_CORE   = 1'b0;
    localparam logic ID_LOADER = 1'b1;

    state_e      state_q, state_d;
    logic        win_q, win_d;       // id of the requester owning the transaction
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        prio_q, prio_d;     // id that wins the next tie
    logic        arb_win_s;

    logic        c_gnt_q, c_gnt_d;
    logic        l_gnt_q, l_gnt_d;
    logic        c_rvalid_q, c_rvalid_d;
    logic        l_rvalid_q, l_rvalid_d;
    logic [63:0] c_rdata_q, c_rdata_d;
    logic [63:0] l_rdata_q, l_rdata_d;
    logic [63:0] m_addr_q, m_addr_d;
    logic [63:0] m_wdata_q, m_wdata_d;
    logic        m_rd_q, m_rd_d;
    logic        m_wr_q, m_wr_d;
    logic        busy_q, busy_d;

    // Pick the winner among the current requests; a tie goes to the priority holder.
    always_comb begin
        if (bus.c_req && bus.l_req) begin
            arb_win_s = prio_q;
        end else if (bus.l_req) begin
            arb_win_s = ID_LOADER;
        end else begin
            arb_win_s = ID_CORE;
        end
    end

    // Next-state and transaction-latch logic.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.c_req || bus.l_req) begin
                    state_d = ST_ISSUE;
                    win_d   = arb_win_s;
                    if (arb_win_s == ID_LOADER) begin
                        we_d    = bus.l_we;
                        addr_d  = bus.l_addr;
                        wdata_d = bus.l_wdata;
                    end else begin
                        we_d    = bus.c_we;
                        addr_d  = bus.c_addr;
                        wdata_d = bus.c_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The requester just served loses the next tie.
                prio_d = ~win_q;
                if (we_q) begin
                    state_d = ST_IDLE;
                end else if (MEM_LAT == 0) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so they can be registered.
    always_comb begin
        c_gnt_d    = (state_d == ST_ISSUE) && (win_d == ID_CORE);
        l_gnt_d    = (state_d == ST_ISSUE) && (win_d == ID_LOADER);
        m_rd_d     = (state_d == ST_ISSUE) && !we_d;
        m_wr_d     = (state_d == ST_ISSUE) && we_d;
        c_rvalid_d = (state_d == ST_RESP) && (win_d == ID_CORE);
        l_rvalid_d = (state_d == ST_RESP) && (win_d == ID_LOADER);
        busy_d     = (state_d != ST_IDLE);
        if (state_d == ST_ISSUE) begin
            m_addr_d  = addr_d;
            m_wdata_d = wdata_d;
        end else begin
            m_addr_d  = m_addr_q;
            m_wdata_d = m_wdata_q;
        end
        // Entering RESP is the sampling point for memory read data.
        if (c_rvalid_d) begin
            c_rdata_d = bus.m_rdata;
        end else begin
            c_rdata_d = c_rdata_q;
        end
        if (l_rvalid_d) begin
            l_rdata_d = bus.m_rdata;
        end else begin
            l_rdata_d = l_rdata_q;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction latch, latency counter and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q   <= ID_CORE;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            cnt_q   <= 2'd0;
            prio_q  <= ID_CORE;
        end else begin
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_gnt_q    <= 1'b0;
            l_gnt_q    <= 1'b0;
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            c_rdata_q  <= 64'd0;
            l_rdata_q  <= 64'd0;
            m_addr_q   <= 64'd0;
            m_wdata_q  <= 64'd0;
            m_rd_q     <= 1'b0;
            m_wr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            c_gnt_q    <= c_gnt_d;
            l_gnt_q    <= l_gnt_d;
            c_rvalid_q <= c_rvalid_d;
            l_rvalid_q <= l_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            l_rdata_q  <= l_rdata_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_rd_q     <= m_rd_d;
            m_wr_q     <= m_wr_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.c_gnt      = c_gnt_q;
    assign bus.l_gnt      = l_gnt_q;
    assign bus.c_rvalid   = c_rvalid_q;
    assign bus.l_rvalid   = l_rvalid_q;
    assign bus.c_rdata    = c_rdata_q;
    assign bus.l_rdata    = l_rdata_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_wdata    = m_wdata_q;
    assign bus.m_MemRead  = m_rd_q;
    assign bus.m_MemWrite = m_wr_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (MEM_LAT 0, 1, 3) share one set of
// requester inputs. Each instance sees memory data that is only correct during
// its own sampling cycle, so early or late sampling shows up as wrong rdata.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   issue_cyc = -100;
    logic [63:0] cur_mem = 64'd0;

    logic        c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
    logic [63:0] c_addr = 64'd0, c_wdata = 64'd0, l_addr = 64'd0, l_wdata = 64'd0;

    wire [2:0]  c_gnt_a, l_gnt_a, c_rv_a, l_rv_a, m_rd_a, m_wr_a, busy_a;
    wire [63:0] c_rdata_a [3];
    wire [63:0] l_rdata_a [3];
    wire [63:0] m_addr_a  [3];
    wire [63:0] m_wdata_a [3];

    int n_chk = 0;
    int n_pass = 0;
    logic [63:0] exp_c_rdata [3];
    logic [63:0] exp_l_rdata [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT_G = (g == 2) ? 3 : g;
        dmem_arbiter_if bus ();
        assign bus.c_req   = c_req;
        assign bus.c_we    = c_we;
        assign bus.c_addr  = c_addr;
        assign bus.c_wdata = c_wdata;
        assign bus.l_req   = l_req;
        assign bus.l_we    = l_we;
        assign bus.l_addr  = l_addr;
        assign bus.l_wdata = l_wdata;
        assign bus.m_rdata = (cyc == issue_cyc + LAT_G) ? cur_mem : ~cur_mem;
        dmem_arbiter #(.MEM_LAT(LAT_G)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
        assign c_gnt_a[g]   = bus.c_gnt;
        assign l_gnt_a[g]   = bus.l_gnt;
        assign c_rv_a[g]    = bus.c_rvalid;
        assign l_rv_a[g]    = bus.l_rvalid;
        assign m_rd_a[g]    = bus.m_MemRead;
        assign m_wr_a[g]    = bus.m_MemWrite;
        assign busy_a[g]    = bus.busy;
        assign c_rdata_a[g] = bus.c_rdata;
        assign l_rdata_a[g] = bus.l_rdata;
        assign m_addr_a[g]  = bus.m_addr;
        assign m_wdata_a[g] = bus.m_wdata;
    end

    function automatic int lat_of(input int d);
        return (d == 2) ? 3 : d;
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s lat%0d t=%0t: got %h expected %h", nm, lat_of(d), $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int d, input logic act, input logic exp);
        chk(nm, d, {63'd0, act}, {63'd0, exp});
    endtask

    task automatic check_reset_state(input string nm);
        for (int d = 0; d < 3; d++) begin
            chk({nm, "_ctl"}, d,
                {57'd0, c_gnt_a[d], l_gnt_a[d], c_rv_a[d], l_rv_a[d], m_rd_a[d], m_wr_a[d], busy_a[d]}, 64'd0);
            chk({nm, "_m_addr"}, d, m_addr_a[d], 64'd0);
            chk({nm, "_m_wdata"}, d, m_wdata_a[d], 64'd0);
            chk({nm, "_c_rdata"}, d, c_rdata_a[d], 64'd0);
            chk({nm, "_l_rdata"}, d, l_rdata_a[d], 64'd0);
            exp_c_rdata[d] = 64'd0;
            exp_l_rdata[d] = 64'd0;
        end
    endtask

    // Expected outputs k cycles after the IDLE sampling edge (k=1 is ISSUE).
    task automatic check_cycle(input int d, input int k, input logic w, input logic we_w,
                               input logic [63:0] a, input logic [63:0] wd, input logic [63:0] mem);
        int   l;
        logic ld;
        logic rv;
        l  = lat_of(d);
        ld = !we_w;
        rv = ld && (k == 2 + l);
        if (rv && w) exp_l_rdata[d] = mem;
        if (rv && !w) exp_c_rdata[d] = mem;
        chk1("c_gnt", d, c_gnt_a[d], (k == 1) && !w);
        chk1("l_gnt", d, l_gnt_a[d], (k == 1) && w);
        chk1("m_MemRead", d, m_rd_a[d], (k == 1) && ld);
        chk1("m_MemWrite", d, m_wr_a[d], (k == 1) && !ld);
        chk1("c_rvalid", d, c_rv_a[d], rv && !w);
        chk1("l_rvalid", d, l_rv_a[d], rv && w);
        chk1("busy", d, busy_a[d], ld ? (k <= 2 + l) : (k == 1));
        chk("c_rdata", d, c_rdata_a[d], exp_c_rdata[d]);
        chk("l_rdata", d, l_rdata_a[d], exp_l_rdata[d]);
        if (k == 1) begin
            chk("m_addr", d, m_addr_a[d], a);
            chk("m_wdata", d, m_wdata_a[d], wd);
        end
    endtask

    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [63:0] c_addr;
        logic [63:0] c_wdata;
        logic        l_req;
        logic        l_we;
        logic [63:0] l_addr;
        logic [63:0] l_wdata;
        logic [63:0] mem;
        logic        exp_win;   // 0 = core, 1 = loader
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        logic        w, we_w;
        logic [63:0] a_w, wd_w;
        int          nk;
        int          grants[$];
        int          exp_rr [4];

        // Round-robin state is tracked by hand: it starts at core and flips to
        // the other requester after every grant.
        vecs[0] = '{1'b1, 1'b0, 64'h10, 64'h0,    1'b0, 1'b0, 64'h0,  64'h0,    64'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 64'h0,  64'h0,    1'b1, 1'b1, 64'h20, 64'h1234, 64'h0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 64'h30, 64'hAAAA, 1'b1, 1'b0, 64'h40, 64'h0,    64'h0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 64'h50, 64'h0,    1'b1, 1'b0, 64'h60, 64'h0,    64'h0123_4567_89AB_CDEF, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b1, 1'b1, 64'h80, 64'h77, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 64'h90, 64'h5555, 1'b0, 1'b0, 64'h0,  64'h0,    64'h0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 64'hA0, 64'h0,    1'b1, 1'b0, 64'hB1, 64'h0,    64'h1111, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 64'h0,  64'h0,    1'b1, 1'b0, 64'hC0, 64'h0,    64'h2222, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 64'hD0, 64'h1,    1'b1, 1'b1, 64'hE0, 64'h2,    64'h0, 1'b0};
        exp_rr = '{0, 1, 0, 1};

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // Table of single transactions; requests drop (and inputs scramble) right after ISSUE.
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            c_req = vecs[v].c_req;  c_we = vecs[v].c_we;
            c_addr = vecs[v].c_addr; c_wdata = vecs[v].c_wdata;
            l_req = vecs[v].l_req;  l_we = vecs[v].l_we;
            l_addr = vecs[v].l_addr; l_wdata = vecs[v].l_wdata;
            cur_mem = vecs[v].mem;
            issue_cyc = cyc + 1;
            w    = vecs[v].exp_win;
            we_w = w ? vecs[v].l_we : vecs[v].c_we;
            a_w  = w ? vecs[v].l_addr : vecs[v].c_addr;
            wd_w = w ? vecs[v].l_wdata : vecs[v].c_wdata;
            nk   = we_w ? 2 : 6;
            for (int k = 1; k <= nk; k++) begin
                @(negedge clk);
                for (int d = 0; d < 3; d++) check_cycle(d, k, w, we_w, a_w, wd_w, vecs[v].mem);
                if (k == 1) begin
                    c_req = 1'b0; l_req = 1'b0;
                    c_we = ~c_we; l_we = ~l_we;
                    c_addr = ~c_addr; l_addr = ~l_addr;
                    c_wdata = ~c_wdata; l_wdata = ~l_wdata;
                end
            end
        end

        // Reset while the load is in WAIT abandons it.
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h400; l_req = 1'b0;
        cur_mem = 64'h7777; issue_cyc = cyc + 1;
        @(negedge clk);
        chk1("abort_gnt", 1, c_gnt_a[1], 1'b1);
        c_req = 1'b0;
        @(negedge clk);
        chk1("abort_busy_wait", 1, busy_a[1], 1'b1);
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("after_abort", d, {58'd0, c_gnt_a[d], c_rv_a[d], l_rv_a[d], m_rd_a[d], m_wr_a[d], busy_a[d]}, 64'd0);
            end
        end

        // Both requesters held continuously: core loads, loader stores.
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h200;
        l_req = 1'b1; l_we = 1'b1; l_addr = 64'h300; l_wdata = 64'h55;
        for (int i = 0; i < 40 && grants.size() < 4; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk1("gnt_excl", d, c_gnt_a[d] & l_gnt_a[d], 1'b0);
                chk1("strobe_excl", d, m_rd_a[d] & m_wr_a[d], 1'b0);
                chk1("rvalid_excl", d, c_rv_a[d] & l_rv_a[d], 1'b0);
            end
            chk1("store_no_rvalid", 1, l_rv_a[1], 1'b0);
            if (c_gnt_a[1]) grants.push_back(0);
            if (l_gnt_a[1]) grants.push_back(1);
        end
        chk("rr_grant_count", 1, 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size() && i < 4; i++) begin
            chk("rr_order", 1, 64'(grants[i]), 64'(exp_rr[i]));
        end
        c_req = 1'b0; l_req = 1'b0;
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
